// File: rtl/rf_pkg.sv
// Shared defaults and packed read-port slicing helpers for the multi-port register file.
package rf_pkg;

   localparam int BIT_WIDTH_D = 32;
   localparam int REG_WIDTH_D = 4;
   localparam int NUM_RD_MAX  = 4;

   // Low bit of port k's field in a packed per-port bus of width w
   function automatic int slice_lo(input int k, input int w);
      return k * w;
   endfunction

   function automatic bit num_rd_ok(input int n);
      return (n >= 1) && (n <= NUM_RD_MAX);
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: same-cycle write forwarding, hardwired-zero masking and busy lookup.
module rf_read_port import rf_pkg::*; #(
   parameter int BIT_WIDTH = BIT_WIDTH_D,
   parameter int REG_WIDTH = REG_WIDTH_D,
   parameter int ZERO_REG  = 1,
   parameter int BYPASS    = 1
) (
   input  logic [REG_WIDTH-1:0] addr,
   input  logic [BIT_WIDTH-1:0] stored,
   input  logic                 stored_busy,
   input  logic                 wrtEn0,
   input  logic [REG_WIDTH-1:0] dr0,
   input  logic [BIT_WIDTH-1:0] dIn0,
   input  logic                 wrtEn1,
   input  logic [REG_WIDTH-1:0] dr1,
   input  logic [BIT_WIDTH-1:0] dIn1,
   input  logic                 issueEn,
   input  logic [REG_WIDTH-1:0] issueDr,
   output logic [BIT_WIDTH-1:0] data,
   output logic                 busy
);

   logic hit0, hit1, iss_hit;

   assign hit0    = wrtEn0 && (dr0 == addr);
   assign hit1    = wrtEn1 && (dr1 == addr);
   assign iss_hit = issueEn && (issueDr == addr);

   always_comb begin
      data = stored;
      busy = stored_busy;
      if (BYPASS != 0) begin
         // Port 1 wins the forward, matching its priority in storage
         if (hit1)      data = dIn1;
         else if (hit0) data = dIn0;
         if ((hit0 || hit1) && !iss_hit) busy = 1'b0;
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
         data = '0;
         busy = 1'b0;
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Two-write, NUM_RD-read register file with per-register busy scoreboard and write-collision flag.
module register_file_mp import rf_pkg::*; #(
   parameter int BIT_WIDTH = BIT_WIDTH_D,
   parameter int REG_WIDTH = REG_WIDTH_D,
   parameter int NUM_RD    = 2,
   parameter int ZERO_REG  = 1,
   parameter int BYPASS    = 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          wrtEn0,
   input  logic [REG_WIDTH-1:0]          dr0,
   input  logic [BIT_WIDTH-1:0]          dIn0,
   input  logic                          wrtEn1,
   input  logic [REG_WIDTH-1:0]          dr1,
   input  logic [BIT_WIDTH-1:0]          dIn1,
   input  logic                          issueEn,
   input  logic [REG_WIDTH-1:0]          issueDr,
   input  logic [NUM_RD*REG_WIDTH-1:0]   rdAddr,
   output logic [NUM_RD*BIT_WIDTH-1:0]   rdData,
   output logic [NUM_RD-1:0]             rdBusy,
   output logic                          wrCollide
);

   localparam int REG_SIZE = 1 << REG_WIDTH;

   if (!num_rd_ok(NUM_RD)) begin : g_bad_num_rd
      $error("register_file_mp: NUM_RD must be 1..4");
   end

   logic [BIT_WIDTH-1:0] regs [REG_SIZE];
   logic [REG_SIZE-1:0]  busy_q, busy_n;
   logic                 we0, we1, iss;

   // Writes/issues aimed at a hardwired-zero R0 are dropped here
   assign we0 = wrtEn0  && !((ZERO_REG != 0) && (dr0 == '0));
   assign we1 = wrtEn1  && !((ZERO_REG != 0) && (dr1 == '0));
   assign iss = issueEn && !((ZERO_REG != 0) && (issueDr == '0));

   // Issue applied last so it wins over a same-cycle writeback
   always_comb begin
      busy_n = busy_q;
      if (we0) busy_n[dr0] = 1'b0;
      if (we1) busy_n[dr1] = 1'b0;
      if (iss) busy_n[issueDr] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < REG_SIZE; i++) regs[i] <= '0;
         busy_q    <= '0;
         wrCollide <= 1'b0;
      end else begin
         if (we0) regs[dr0] <= dIn0;
         if (we1) regs[dr1] <= dIn1;
         busy_q    <= busy_n;
         wrCollide <= wrtEn0 && wrtEn1 && (dr0 == dr1);
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [REG_WIDTH-1:0] a;
      assign a = rdAddr[slice_lo(k, REG_WIDTH) +: REG_WIDTH];

      rf_read_port #(
         .BIT_WIDTH (BIT_WIDTH),
         .REG_WIDTH (REG_WIDTH),
         .ZERO_REG  (ZERO_REG),
         .BYPASS    (BYPASS)
      ) u_rd (
         .addr        (a),
         .stored      (regs[a]),
         .stored_busy (busy_q[a]),
         .wrtEn0      (wrtEn0),
         .dr0         (dr0),
         .dIn0        (dIn0),
         .wrtEn1      (wrtEn1),
         .dr1         (dr1),
         .dIn1        (dIn1),
         .issueEn     (issueEn),
         .issueDr     (issueDr),
         .data        (rdData[slice_lo(k, BIT_WIDTH) +: BIT_WIDTH]),
         .busy        (rdBusy[k])
      );
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench: two configurations (zero-reg+bypass, 4 reads / plain storage, 2 reads) driven in lockstep.
module tb_register_file_mp;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wrtEn0, wrtEn1, issueEn;
   logic [3:0]  dr0, dr1, issueDr;
   logic [31:0] dIn0, dIn1;
   logic [3:0]  ra [4];
   logic [15:0]  rdAddrA;
   logic [7:0]   rdAddrB;
   logic [127:0] rdDataA;
   logic [63:0]  rdDataB;
   logic [3:0]   rdBusyA;
   logic [1:0]   rdBusyB;
   logic         collA, collB;

   assign rdAddrA = {ra[3], ra[2], ra[1], ra[0]};
   assign rdAddrB = {ra[1], ra[0]};

   always #5 clk = ~clk;

   register_file_mp #(.BIT_WIDTH(32), .REG_WIDTH(4), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .wrtEn0(wrtEn0), .dr0(dr0), .dIn0(dIn0),
      .wrtEn1(wrtEn1), .dr1(dr1), .dIn1(dIn1), .issueEn(issueEn), .issueDr(issueDr),
      .rdAddr(rdAddrA), .rdData(rdDataA), .rdBusy(rdBusyA), .wrCollide(collA));

   register_file_mp #(.BIT_WIDTH(32), .REG_WIDTH(4), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .wrtEn0(wrtEn0), .dr0(dr0), .dIn0(dIn0),
      .wrtEn1(wrtEn1), .dr1(dr1), .dIn1(dIn1), .issueEn(issueEn), .issueDr(issueDr),
      .rdAddr(rdAddrB), .rdData(rdDataB), .rdBusy(rdBusyB), .wrCollide(collB));

   typedef struct {
      string       tag;
      int          d;
      int          p;
      bit          isb;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   nvec = 0;
   int   nerr = 0;

   // Reference state: index 0 = zero-reg/bypass config, 1 = plain config
   logic [31:0] mreg  [2][16];
   logic        mbusy [2][16];
   logic        mcoll;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int nports(input int d);
      return (d == 0) ? 4 : 2;
   endfunction

   function automatic logic [31:0] m_data(input int d, input logic [3:0] a);
      if (d == 0 && a == 4'd0) return 32'h0;
      if (d == 0 && wrtEn1 && dr1 == a) return dIn1;
      if (d == 0 && wrtEn0 && dr0 == a) return dIn0;
      return mreg[d][a];
   endfunction

   function automatic logic m_busy(input int d, input logic [3:0] a);
      if (d == 0 && a == 4'd0) return 1'b0;
      if (d == 0 && ((wrtEn1 && dr1 == a) || (wrtEn0 && dr0 == a)) && !(issueEn && issueDr == a))
         return 1'b0;
      return mbusy[d][a];
   endfunction

   function automatic logic [31:0] obs(input int d, input int p, input bit isb);
      if (d == 0) return isb ? {31'b0, rdBusyA[p]} : rdDataA[p*32 +: 32];
      return isb ? {31'b0, rdBusyB[p]} : rdDataB[p*32 +: 32];
   endfunction

   task automatic push(input string tag, input int d, input int p, input bit isb, input logic [31:0] e);
      exp_t x;
      x.tag = tag; x.d = d; x.p = p; x.isb = isb; x.exp = e;
      q.push_back(x);
   endtask

   task automatic m_reset();
      for (int d = 0; d < 2; d++)
         for (int r = 0; r < 16; r++) begin
            mreg[d][r]  = 32'h0;
            mbusy[d][r] = 1'b0;
         end
      mcoll = 1'b0;
   endtask

   task automatic m_edge();
      for (int d = 0; d < 2; d++) begin
         if (wrtEn0 && !(d == 0 && dr0 == 4'd0)) begin mreg[d][dr0] = dIn0; mbusy[d][dr0] = 1'b0; end
         if (wrtEn1 && !(d == 0 && dr1 == 4'd0)) begin mreg[d][dr1] = dIn1; mbusy[d][dr1] = 1'b0; end
         if (issueEn && !(d == 0 && issueDr == 4'd0)) mbusy[d][issueDr] = 1'b1;
      end
      mcoll = wrtEn0 && wrtEn1 && (dr0 == dr1);
   endtask

   task automatic idle();
      wrtEn0 = 0; wrtEn1 = 0; issueEn = 0;
      dr0 = 0; dr1 = 0; issueDr = 0; dIn0 = 0; dIn1 = 0;
   endtask

   // Queue model expectations for the inputs now applied, drain against the DUTs, then clock
   task automatic tick();
      exp_t x;
      #1;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < nports(d); p++) begin
            push("rd", d, p, 1'b0, m_data(d, ra[p]));
            push("busy", d, p, 1'b1, {31'b0, m_busy(d, ra[p])});
         end
      while (q.size() > 0) begin
         x = q.pop_front();
         chk($sformatf("%s d%0d p%0d", x.tag, x.d, x.p), obs(x.d, x.p, x.isb), x.exp);
      end
      @(posedge clk);
      if (reset_n) m_edge();
      #1;
      chk("collA", {31'b0, collA}, {31'b0, mcoll});
      chk("collB", {31'b0, collB}, {31'b0, mcoll});
   endtask

   task automatic set_ra(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3);
      ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
   endtask

   initial begin
      idle();
      set_ra(0, 1, 2, 3);
      m_reset();
      reset_n = 0;
      #3;
      for (int p = 0; p < 4; p++) push("rst rdA", 0, p, 1'b0, 32'h0);
      for (int p = 0; p < 2; p++) push("rst busyB", 1, p, 1'b1, 32'h0);
      chk("rst collA", {31'b0, collA}, 32'h0);
      @(posedge clk); #1;
      tick();
      reset_n = 1;

      // Fill regs 1..15, then assert reset mid-cycle
      for (int i = 1; i < 16; i++) begin
         wrtEn0 = 1; dr0 = 4'(i); dIn0 = 32'hA5A5_0000 + i;
         issueEn = 1; issueDr = 4'(16 - i);
         tick();
      end
      idle();
      set_ra(15, 1, 8, 14);
      push("pre-rst r1", 1, 1, 1'b0, 32'hA5A5_0001);
      tick();
      #2 reset_n = 0;
      m_reset();
      push("mid-rst r15", 0, 0, 1'b0, 32'h0);
      push("mid-rst busy r14", 0, 3, 1'b1, 32'h0);
      tick();
      reset_n = 1;
      tick();

      // Write-port priority and collision pulse
      wrtEn0 = 1; wrtEn1 = 1; dr0 = 5; dr1 = 5; dIn0 = 32'h11; dIn1 = 32'h22;
      set_ra(5, 5, 0, 0);
      push("prio bypass A", 0, 0, 1'b0, 32'h22);
      tick();
      chk("collide pulse", {31'b0, collA}, 32'h1);
      idle();
      push("prio A", 0, 0, 1'b0, 32'h22);
      push("prio B", 1, 1, 1'b0, 32'h22);
      tick();
      chk("collide drop", {31'b0, collB}, 32'h0);

      // Bypass vs registered visibility
      wrtEn0 = 1; dr0 = 3; dIn0 = 32'hDEAD;
      set_ra(3, 3, 3, 3);
      push("byp A", 0, 0, 1'b0, 32'hDEAD);
      push("nobyp B", 1, 0, 1'b0, 32'h0);
      tick();
      idle();
      push("byp next B", 1, 0, 1'b0, 32'hDEAD);
      tick();

      // Hardwired zero
      wrtEn0 = 1; dr0 = 0; dIn0 = 32'hFFFF_FFFF; issueEn = 1; issueDr = 0;
      set_ra(0, 0, 0, 0);
      tick();
      idle();
      push("zero A", 0, 0, 1'b0, 32'h0);
      push("zero busy A", 0, 1, 1'b1, 32'h0);
      push("r0 B", 1, 0, 1'b0, 32'hFFFF_FFFF);
      tick();

      // Scoreboard: issue, issue+writeback, lone writeback
      issueEn = 1; issueDr = 7;
      set_ra(7, 7, 7, 7);
      tick();
      idle();
      push("issued A", 0, 0, 1'b1, 32'h1);
      push("issued B", 1, 0, 1'b1, 32'h1);
      tick();
      issueEn = 1; issueDr = 7; wrtEn0 = 1; dr0 = 7; dIn0 = 32'h77;
      push("iss+wb A", 0, 0, 1'b1, 32'h1);
      tick();
      idle();
      push("iss wins A", 0, 1, 1'b1, 32'h1);
      push("iss wins B", 1, 1, 1'b1, 32'h1);
      tick();
      wrtEn1 = 1; dr1 = 7; dIn1 = 32'h78;
      push("wb fwd A", 0, 0, 1'b1, 32'h0);
      push("wb B", 1, 0, 1'b1, 32'h1);
      tick();
      idle();
      push("wb done A", 0, 2, 1'b1, 32'h0);
      push("wb done B", 1, 0, 1'b1, 32'h0);
      tick();

      // Multi-read on the same address
      wrtEn0 = 1; dr0 = 9; dIn0 = 32'h1234;
      tick();
      idle();
      set_ra(9, 9, 9, 9);
      for (int p = 0; p < 4; p++) push("multi A", 0, p, 1'b0, 32'h1234);
      tick();

      // Random traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         wrtEn0 = 1'($urandom_range(0, 1)); dr0 = 4'($urandom_range(0, 15)); dIn0 = $urandom;
         wrtEn1 = 1'($urandom_range(0, 1)); dr1 = 4'($urandom_range(0, 15)); dIn1 = $urandom;
         issueEn = 1'($urandom_range(0, 1)); issueDr = 4'($urandom_range(0, 15));
         if (n % 5 == 0) dr1 = dr0;
         for (int p = 0; p < 4; p++) ra[p] = (p == 0 && n % 3 == 0) ? dr0 : 4'($urandom_range(0, 15));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
